// File: rtl/wb_stage.sv
// Writeback stage: queues ALU results, arbitrates the single register-file write port with the
// load unit, commits flags, serves two read ports and flags R15 writes. Option: WB_BYPASS_EN.
module wb_stage #(
   parameter int DATA_W     = 32,
   parameter int NREG       = 16,
   parameter int QDEPTH     = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [$clog2(NREG)-1:0] alu_rd_idx,
   input  logic [DATA_W-1:0]       alu_rd_data,
   input  logic                    alu_wr,
   input  logic                    alu_s,
   input  logic                    alu_n,
   input  logic                    alu_z,
   input  logic                    alu_c,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [$clog2(NREG)-1:0] ld_idx,
   input  logic [DATA_W-1:0]       ld_data,
   input  logic [$clog2(NREG)-1:0] ra_idx,
   input  logic [$clog2(NREG)-1:0] rb_idx,
   output logic [DATA_W-1:0]       ra_data,
   output logic [DATA_W-1:0]       rb_data,
   output logic [2:0]              flags_nzc,
   output logic                    pc_wr,
   output logic [DATA_W-1:0]       pc_val,
   output logic                    busy
);
   localparam int IDX_W = $clog2(NREG);
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   logic [DATA_W-1:0] regs_q   [NREG];
   logic [DATA_W-1:0] regs_d   [NREG];
   logic [IDX_W-1:0]  e_idx_q  [QDEPTH];
   logic [IDX_W-1:0]  e_idx_d  [QDEPTH];
   logic [DATA_W-1:0] e_data_q [QDEPTH];
   logic [DATA_W-1:0] e_data_d [QDEPTH];
   logic              e_wr_q   [QDEPTH];
   logic              e_wr_d   [QDEPTH];
   logic              e_s_q    [QDEPTH];
   logic              e_s_d    [QDEPTH];
   logic [2:0]        e_nzc_q  [QDEPTH];
   logic [2:0]        e_nzc_d  [QDEPTH];

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [2:0]        flags_q, flags_d;
   logic              pc_wr_q, pc_wr_d;
   logic [DATA_W-1:0] pc_val_q, pc_val_d;

   logic              full, empty, load_win, pop, push;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;

   assign full      = (count_q == CNT_W'(QDEPTH));
   assign empty     = (count_q == '0);
   assign alu_ready = !full && !rst;
   // A load only yields to the queue once the head entry has been starved long enough.
   assign load_win  = ld_valid && (empty || (starve_q < ST_W'(STARVE_MAX)));
   assign pop       = !empty && !load_win;
   assign ld_ready  = load_win && !rst;
   assign push      = alu_valid && alu_ready;

   always_comb begin
      regs_d   = regs_q;
      e_idx_d  = e_idx_q;
      e_data_d = e_data_q;
      e_wr_d   = e_wr_q;
      e_s_d    = e_s_q;
      e_nzc_d  = e_nzc_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      starve_d = starve_q;
      flags_d  = flags_q;
      wr_en    = 1'b0;
      wr_idx   = ld_idx;
      wr_data  = ld_data;

      if (push) begin
         e_idx_d[tail_q]  = alu_rd_idx;
         e_data_d[tail_q] = alu_rd_data;
         e_wr_d[tail_q]   = alu_wr;
         e_s_d[tail_q]    = alu_s;
         e_nzc_d[tail_q]  = {alu_n, alu_z, alu_c};
         tail_d           = tail_q + 1'b1;
      end

      if (load_win) begin
         wr_en = 1'b1;
      end else if (pop) begin
         wr_en   = e_wr_q[head_q];
         wr_idx  = e_idx_q[head_q];
         wr_data = e_data_q[head_q];
         if (e_s_q[head_q]) flags_d = e_nzc_q[head_q];
         head_d = head_q + 1'b1;
      end

      if (wr_en) regs_d[wr_idx] = wr_data;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (pop || empty)
         starve_d = '0;
      else if (load_win && (starve_q != ST_W'(STARVE_MAX)))
         starve_d = starve_q + 1'b1;

      pc_wr_d  = wr_en && (wr_idx == IDX_W'(NREG - 1));
      pc_val_d = pc_wr_d ? wr_data : pc_val_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            e_idx_q[i]  <= '0;
            e_data_q[i] <= '0;
            e_wr_q[i]   <= 1'b0;
            e_s_q[i]    <= 1'b0;
            e_nzc_q[i]  <= '0;
         end
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         flags_q  <= '0;
         pc_wr_q  <= 1'b0;
         pc_val_q <= '0;
      end else begin
         regs_q   <= regs_d;
         e_idx_q  <= e_idx_d;
         e_data_q <= e_data_d;
         e_wr_q   <= e_wr_d;
         e_s_q    <= e_s_d;
         e_nzc_q  <= e_nzc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         flags_q  <= flags_d;
         pc_wr_q  <= pc_wr_d;
         pc_val_q <= pc_val_d;
      end
   end

`ifdef WB_BYPASS_EN
   // Walk queue oldest-to-youngest so the youngest matching entry wins; queue beats load.
   always_comb begin
      logic [PTR_W-1:0] slot;
      ra_data = regs_q[ra_idx];
      rb_data = regs_q[rb_idx];
      if (ld_ready && (ld_idx == ra_idx)) ra_data = ld_data;
      if (ld_ready && (ld_idx == rb_idx)) rb_data = ld_data;
      for (int k = 0; k < QDEPTH; k++) begin
         slot = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && e_wr_q[slot]) begin
            if (e_idx_q[slot] == ra_idx) ra_data = e_data_q[slot];
            if (e_idx_q[slot] == rb_idx) rb_data = e_data_q[slot];
         end
      end
   end
`else
   assign ra_data = regs_q[ra_idx];
   assign rb_data = regs_q[rb_idx];
`endif

   assign flags_nzc = flags_q;
   assign pc_wr     = pc_wr_q;
   assign pc_val    = pc_val_q;
   assign busy      = !empty;
endmodule
